// File: rtl/instruction_fetch_stage.sv
// rtl/instruction_fetch_stage.sv - MIPS fetch stage: PC, IF/ID register, retired-fetch counter
module instruction_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h00000000
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Stall,
  input  logic        Flush,
  input  logic        RedirectValid,
  input  logic [31:0] RedirectTarget,
  output logic [31:0] PCAddress,
  input  logic [31:0] IMemInstruction,
  output logic [31:0] IF_ID_Instruction,
  output logic [31:0] IF_ID_PCPlus4,
  output logic        IF_ID_Valid,
  output logic [31:0] FetchCount
);

  logic [31:0] pc;
  logic [31:0] pc_plus4;

  assign pc_plus4  = pc + 32'd4;
  assign PCAddress = pc;

  // A redirect wins over a stall for the PC.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      pc <= {RESET_PC[31:2], 2'b00};
    end else if (RedirectValid) begin
      pc <= {RedirectTarget[31:2], 2'b00};
    end else if (!Stall) begin
      pc <= pc_plus4;
    end
  end

  // A redirect squashes the wrong-path instruction being fetched this cycle.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      IF_ID_Instruction <= 32'h00000000;
      IF_ID_PCPlus4     <= 32'h00000000;
      IF_ID_Valid       <= 1'b0;
      FetchCount        <= 32'h00000000;
    end else if (Flush || RedirectValid) begin
      IF_ID_Instruction <= 32'h00000000;
      IF_ID_PCPlus4     <= 32'h00000000;
      IF_ID_Valid       <= 1'b0;
    end else if (!Stall) begin
      IF_ID_Instruction <= IMemInstruction;
      IF_ID_PCPlus4     <= pc_plus4;
      IF_ID_Valid       <= 1'b1;
      FetchCount        <= FetchCount + 32'd1;
    end
  end

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// tb/tb_instruction_fetch_stage.sv - vector table plus randomized reference-model check of instruction_fetch_stage
module tb_instruction_fetch_stage;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic [31:0] pc_address;
  logic [31:0] imem_instruction;
  logic [31:0] if_id_instruction;
  logic [31:0] if_id_pc_plus4;
  logic        if_id_valid;
  logic [31:0] fetch_count;

  int compared;
  int mismatched;

  instruction_fetch_stage #(.RESET_PC(32'h00000000)) dut (
    .Clk(clk),
    .Reset(rst_n),
    .Stall(stall),
    .Flush(flush),
    .RedirectValid(redirect_valid),
    .RedirectTarget(redirect_target),
    .PCAddress(pc_address),
    .IMemInstruction(imem_instruction),
    .IF_ID_Instruction(if_id_instruction),
    .IF_ID_PCPlus4(if_id_pc_plus4),
    .IF_ID_Valid(if_id_valid),
    .FetchCount(fetch_count)
  );

  // Instruction memory: word i holds i*3.
  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return (addr >> 2) * 32'd3;
  endfunction

  assign imem_instruction = mem_word(pc_address);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [31:0] e_pc, input logic [31:0] e_inst,
                           input logic [31:0] e_pc4, input logic e_v, input logic [31:0] e_cnt);
    check({tag, " pc"}, pc_address, e_pc);
    check({tag, " inst"}, if_id_instruction, e_inst);
    check({tag, " pc4"}, if_id_pc_plus4, e_pc4);
    check({tag, " valid"}, {31'd0, if_id_valid}, {31'd0, e_v});
    check({tag, " count"}, fetch_count, e_cnt);
  endtask

  typedef struct {
    logic        st;
    logic        fl;
    logic        rv;
    logic [31:0] tg;
    logic [31:0] e_pc;
    logic [31:0] e_inst;
    logic [31:0] e_pc4;
    logic        e_v;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t vecs [14];

  // Behavioural model state
  logic [31:0] m_pc, m_inst, m_pc4, m_cnt;
  logic        m_v;

  task automatic model_reset();
    m_pc = 32'h0; m_inst = 32'h0; m_pc4 = 32'h0; m_v = 1'b0; m_cnt = 32'h0;
  endtask

  task automatic model_edge(input logic st, input logic fl, input logic rv, input logic [31:0] tg);
    logic [31:0] cur;
    cur = m_pc;
    if (rv)       m_pc = tg & 32'hFFFF_FFFC;
    else if (!st) m_pc = cur + 32'd4;
    if (fl || rv) begin
      m_inst = 32'h0; m_pc4 = 32'h0; m_v = 1'b0;
    end else if (!st) begin
      m_inst = mem_word(cur); m_pc4 = cur + 32'd4; m_v = 1'b1; m_cnt = m_cnt + 32'd1;
    end
  endtask

  initial begin
    compared = 0;
    mismatched = 0;
    stall = 1'b0; flush = 1'b0; redirect_valid = 1'b0; redirect_target = 32'h0;
    rst_n = 1'b0;

    vecs[0]  = '{0, 0, 0, 32'h0,          32'h4,          32'd0,          32'd4,  1, 32'd1};
    vecs[1]  = '{0, 0, 0, 32'h0,          32'h8,          32'd3,          32'd8,  1, 32'd2};
    vecs[2]  = '{1, 0, 0, 32'h0,          32'h8,          32'd3,          32'd8,  1, 32'd2};
    vecs[3]  = '{1, 0, 0, 32'h0,          32'h8,          32'd3,          32'd8,  1, 32'd2};
    vecs[4]  = '{1, 0, 0, 32'h0,          32'h8,          32'd3,          32'd8,  1, 32'd2};
    vecs[5]  = '{0, 0, 0, 32'h0,          32'hC,          32'd6,          32'd12, 1, 32'd3};
    vecs[6]  = '{0, 0, 1, 32'h43,         32'h40,         32'd0,          32'd0,  0, 32'd3};
    vecs[7]  = '{0, 0, 0, 32'h0,          32'h44,         32'd48,         32'h44, 1, 32'd4};
    vecs[8]  = '{1, 0, 1, 32'h17,         32'h14,         32'd0,          32'd0,  0, 32'd4};
    vecs[9]  = '{1, 1, 0, 32'h0,          32'h14,         32'd0,          32'd0,  0, 32'd4};
    vecs[10] = '{0, 0, 0, 32'h0,          32'h18,         32'd15,         32'd24, 1, 32'd5};
    vecs[11] = '{0, 0, 1, 32'hFFFF_FFFE,  32'hFFFF_FFFC,  32'd0,          32'd0,  0, 32'd5};
    vecs[12] = '{0, 0, 0, 32'h0,          32'h0,          32'hBFFF_FFFD,  32'd0,  1, 32'd6};
    vecs[13] = '{0, 1, 0, 32'h0,          32'h4,          32'd0,          32'd0,  0, 32'd6};

    // Reset held for two edges with noisy control inputs
    stall = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h100;
    repeat (2) @(posedge clk);
    #1 check_all("reset", 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
    @(negedge clk);
    stall = 1'b0; redirect_valid = 1'b0; redirect_target = 32'h0;
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      stall = vecs[i].st; flush = vecs[i].fl;
      redirect_valid = vecs[i].rv; redirect_target = vecs[i].tg;
      @(posedge clk);
      #1 check_all($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_inst, vecs[i].e_pc4,
                   vecs[i].e_v, vecs[i].e_cnt);
      @(negedge clk);
    end
    stall = 1'b0; flush = 1'b0; redirect_valid = 1'b0;

    // Asynchronous reset dropped between edges
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_all("async_reset", 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    // Randomized run against the reference model
    for (int i = 0; i < 400; i++) begin
      stall = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 7) == 0);
      redirect_valid = ($urandom_range(0, 9) == 0);
      redirect_target = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                   : $urandom;
      @(posedge clk);
      model_edge(stall, flush, redirect_valid, redirect_target);
      #1 check_all($sformatf("rand%0d", i), m_pc, m_inst, m_pc4, m_v, m_cnt);
      @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
